// File: rtl/project_cfg_pkg.sv
// Shared configuration and message types for the player link.
// The parity feature of the link is selected by PLAYER_LINK_PARITY_EN.
package project_cfg_pkg;

    localparam int unsigned LINK_CLK_DIV   = 64;
    localparam int unsigned LINK_DATA_BITS = 10;

    typedef struct packed {
        logic       ready_flag;
        logic       hit;
        logic [7:0] ship_cords;
    } link_msg_t;

    function automatic logic even_parity(input link_msg_t msg);
        return ^msg;
    endfunction

endpackage

// File: rtl/link_baud_gen.sv
// Bit-period counter for the player link: tick marks the last cycle of a bit.
// Holding restart keeps the counter at zero so a new frame starts a full period.
module link_baud_gen
    import project_cfg_pkg::*;
#(
    parameter int unsigned CLK_DIV = LINK_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(CLK_DIV - 1));

    // Wraps explicitly at CLK_DIV-1, never through the natural overflow.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/player_link_tx.sv
// Serial transmitter for the player-to-player link: start, 10 data bits LSB first,
// optional even parity (PLAYER_LINK_PARITY_EN), stop. Line idles high.
module player_link_tx
    import project_cfg_pkg::*;
#(
    parameter int unsigned CLK_DIV = LINK_CLK_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] ship_cords,
    input  logic       hit,
    input  logic       ready_flag,
    output logic       tx_line,
    output logic       busy
);

`ifdef PLAYER_LINK_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                    state, state_next;
    logic [3:0]                bit_idx, bit_idx_next;
    link_msg_t                 msg_q;
    logic [LINK_DATA_BITS-1:0] msg_bits;
    logic                      tick;
    logic                      transfer;
    logic                      tx_line_next;

    assign transfer = tx_valid && tx_ready;
    assign msg_bits = msg_q;

    link_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (state == IDLE),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bit_idx <= '0;
            tx_line <= 1'b1;
            busy    <= 1'b0;
            msg_q   <= '0;
        end else begin
            state   <= state_next;
            bit_idx <= bit_idx_next;
            tx_line <= tx_line_next;
            busy    <= (state_next != IDLE);
            if (transfer) begin
                msg_q <= '{ready_flag: ready_flag, hit: hit, ship_cords: ship_cords};
            end
        end
    end

    always_comb begin
        state_next   = state;
        bit_idx_next = bit_idx;
        case (state)
            IDLE:  if (transfer) state_next = START;
            START: if (tick) begin
                state_next   = DATA;
                bit_idx_next = '0;
            end
            DATA:  if (tick) begin
                if (bit_idx == 4'(LINK_DATA_BITS - 1)) begin
                    bit_idx_next = '0;
`ifdef PLAYER_LINK_PARITY_EN
                    state_next   = PARITY;
`else
                    state_next   = STOP;
`endif
                end else begin
                    bit_idx_next = bit_idx + 4'd1;
                end
            end
`ifdef PLAYER_LINK_PARITY_EN
            PARITY: if (tick) state_next = STOP;
`endif
            STOP:  if (tick) state_next = IDLE;
            default: begin
                state_next   = IDLE;
                bit_idx_next = '0;
            end
        endcase
    end

    // Line level is decoded from the next state so tx_line comes straight off a flop.
    always_comb begin
        tx_ready     = (state == IDLE) && !rst;
        tx_line_next = 1'b1;
        case (state_next)
            IDLE:   tx_line_next = 1'b1;
            START:  tx_line_next = 1'b0;
            DATA:   tx_line_next = msg_bits[bit_idx_next];
`ifdef PLAYER_LINK_PARITY_EN
            PARITY: tx_line_next = even_parity(msg_q);
`endif
            STOP:   tx_line_next = 1'b1;
            default: tx_line_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_player_link_tx.sv
// Randomized bench for player_link_tx with a frame-level model and a serial decoder.
// Build with PLAYER_LINK_PARITY_EN defined to exercise the parity frame.
module tb_player_link_tx;

    localparam int unsigned CLK_DIV = 4;
`ifdef PLAYER_LINK_PARITY_EN
    localparam int unsigned NBITS = 13;
    localparam bit          PAR   = 1'b1;
`else
    localparam int unsigned NBITS = 12;
    localparam bit          PAR   = 1'b0;
`endif
    localparam int unsigned FRAME_CYC = NBITS * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] ship_cords;
    logic       hit;
    logic       ready_flag;
    logic       tx_line;
    logic       busy;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cyc = 0;

    logic [9:0] dec_q[$];
    bit         dec_en = 1'b0;

    player_link_tx #(.CLK_DIV(CLK_DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ship_cords (ship_cords),
        .hit        (hit),
        .ready_flag (ready_flag),
        .tx_line    (tx_line),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Frame position idx: 0 start, 1..10 data LSB first, then parity if present, then stop.
    function automatic logic frame_bit(input logic [9:0] p, input int unsigned idx);
        if (idx == 0) return 1'b0;
        if (idx <= 10) return p[idx-1];
        if (PAR && idx == 11) return ($countones(p) % 2) == 1;
        return 1'b1;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [9:0] p);
        ship_cords = p[7:0];
        hit        = p[8];
        ready_flag = p[9];
    endtask

    task automatic wait_ready;
        int unsigned n = 0;
        while (!tx_ready && n < 200) begin
            step;
            n++;
        end
        check_eq("ready_wait", {31'd0, tx_ready}, 32'd1);
    endtask

    task automatic send_frame(input logic [9:0] p, input bit keep_valid, output int unsigned t_edge);
        wait_ready;
        drive(p);
        tx_valid = 1'b1;
        t_edge   = cyc;
        step;
        if (!keep_valid) tx_valid = 1'b0;
        for (int unsigned k = 1; k <= FRAME_CYC; k++) begin
            check_eq($sformatf("line_c%0d", k), {31'd0, tx_line}, {31'd0, frame_bit(p, (k-1)/CLK_DIV)});
            check_eq($sformatf("busy_c%0d", k), {31'd0, busy}, 32'd1);
            check_eq($sformatf("ready_c%0d", k), {31'd0, tx_ready}, 32'd0);
            drive(10'($urandom));
            step;
        end
        check_eq("ready_after", {31'd0, tx_ready}, 32'd1);
        check_eq("busy_after", {31'd0, busy}, 32'd0);
        check_eq("line_after", {31'd0, tx_line}, 32'd1);
        check_eq("dec_count", dec_q.size(), 32'd1);
        if (dec_q.size() > 0) check_eq("dec_payload", {22'd0, dec_q.pop_front()}, {22'd0, p});
    endtask

    // Independent receiver: samples each bit near its middle from the falling start edge.
    initial begin
        forever begin
            @(negedge clk);
            if (dec_en && tx_line === 1'b0) begin
                logic [9:0] d;
                logic       par;
                repeat (CLK_DIV/2) @(negedge clk);
                check_eq("dec_start", {31'd0, tx_line}, 32'd0);
                for (int unsigned i = 0; i < 10; i++) begin
                    repeat (CLK_DIV) @(negedge clk);
                    d[i] = tx_line;
                end
                if (PAR) begin
                    repeat (CLK_DIV) @(negedge clk);
                    par = tx_line;
                    check_eq("dec_parity", {31'd0, par}, {31'd0, ^d});
                end
                repeat (CLK_DIV) @(negedge clk);
                check_eq("dec_stop", {31'd0, tx_line}, 32'd1);
                dec_q.push_back(d);
            end
        end
    end

    initial begin
        int unsigned t1, t2;
        logic [9:0]  p;
        rst      = 1'b1;
        tx_valid = 1'b0;
        drive(10'd0);
        repeat (3) step;
        check_eq("rst_line", {31'd0, tx_line}, 32'd1);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_ready", {31'd0, tx_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("ready_post_rst", {31'd0, tx_ready}, 32'd1);
        step;

        for (int unsigned k = 0; k < 100; k++) begin
            check_eq("idle_line", {31'd0, tx_line}, 32'd1);
            check_eq("idle_busy", {31'd0, busy}, 32'd0);
            check_eq("idle_ready", {31'd0, tx_ready}, 32'd1);
            drive(10'($urandom));
            step;
        end

        // Abort a frame with reset at cycle 20.
        wait_ready;
        p = 10'($urandom);
        drive(p);
        tx_valid = 1'b1;
        step;
        tx_valid = 1'b0;
        for (int unsigned k = 1; k < 20; k++) begin
            check_eq("abort_pre_line", {31'd0, tx_line}, {31'd0, frame_bit(p, (k-1)/CLK_DIV)});
            step;
        end
        rst = 1'b1;
        step;
        check_eq("abort_line", {31'd0, tx_line}, 32'd1);
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_ready", {31'd0, tx_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("abort_ready_rel", {31'd0, tx_ready}, 32'd1);
        step;
        check_eq("abort_line2", {31'd0, tx_line}, 32'd1);
        check_eq("abort_busy2", {31'd0, busy}, 32'd0);
        check_eq("abort_ready2", {31'd0, tx_ready}, 32'd1);

        dec_en = 1'b1;
        send_frame(10'h1A5, 1'b0, t1);

        send_frame(10'($urandom), 1'b1, t1);
        send_frame(10'($urandom), 1'b0, t2);
        check_eq("b2b_gap", t2 - t1, FRAME_CYC + 1);

`ifdef PLAYER_LINK_PARITY_EN
        send_frame(10'h3FF, 1'b0, t1);
        send_frame(10'h001, 1'b0, t1);
`endif

        for (int unsigned n = 0; n < 256; n++) begin
            repeat ($urandom_range(0, 3)) step;
            send_frame(10'($urandom), 1'b0, t1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
